// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch stage: the decoded packet handed over by
// id_stage, the dispatch FSM state encoding and the load/store predicate.
package dispatch_ctrl_pkg;

    localparam int WAY_NUM = 2;

    // One decoded instruction as delivered by id_stage.
    typedef struct packed {
        logic [7:0] tag;
        logic [4:0] dest;
        logic       rd_mem;
        logic       wr_mem;
    } ID_DISPATCH_PACKET;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } DISP_STATE;

    // Any memory access needs an LSQ entry.
    function automatic logic is_lsq_op(input ID_DISPATCH_PACKET p);
        return p.rd_mem | p.wr_mem;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Bundle between id_stage (master) and the dispatch controller (slave),
// including the downstream dispatch lanes and free-entry counts.
//
// Handshake: a group transfers at a rising edge when id_ready_o is high and
// at least one id_valid_i bit is set; id_valid_i is contiguous from lane 0.
// The master holds the group stable until it transfers. disp_valid_o fires
// per lane each cycle and needs no acknowledge: downstream has already
// advertised room through the free counts.
interface dispatch_ctrl_if
    import dispatch_ctrl_pkg::*;
#(
    parameter int WAY   = WAY_NUM,
    parameter int CNT_W = 4
);
    ID_DISPATCH_PACKET [WAY-1:0] id_packet_i;
    logic [WAY-1:0]              id_valid_i;
    logic                        id_ready_o;
    logic [CNT_W-1:0]            rob_free_i;
    logic [CNT_W-1:0]            rs_free_i;
    logic [CNT_W-1:0]            lsq_free_i;
    logic                        flush_i;
    ID_DISPATCH_PACKET [WAY-1:0] disp_packet_o;
    logic [WAY-1:0]              disp_valid_o;

    modport master (
        output id_packet_i, id_valid_i, rob_free_i, rs_free_i, lsq_free_i, flush_i,
        input  id_ready_o, disp_packet_o, disp_valid_o
    );

    modport slave (
        input  id_packet_i, id_valid_i, rob_free_i, rs_free_i, lsq_free_i, flush_i,
        output id_ready_o, disp_packet_o, disp_valid_o
    );
endinterface

// File: rtl/dispatch_ctrl_width_calc.sv
// disp_width_calc: how many buffered lanes (oldest first) fit in the ROB,
// RS and LSQ this cycle. Purely combinational.
module disp_width_calc
    import dispatch_ctrl_pkg::*;
#(
    parameter int WAY   = WAY_NUM,
    parameter int CNT_W = 4
) (
    input  logic [WAY-1:0]             valid,
    input  logic [WAY-1:0]             mem_op,
    input  logic [CNT_W-1:0]           rob_free,
    input  logic [CNT_W-1:0]           rs_free,
    input  logic [CNT_W-1:0]           lsq_free,
    output logic [$clog2(WAY+1)-1:0]   n,
    output logic [WAY-1:0]             fire
);
    localparam int NW = $clog2(WAY+1);

    // Counts above WAY carry no extra meaning for a WAY-wide group.
    function automatic int sat_way(input logic [CNT_W-1:0] c);
        return (int'(c) > WAY) ? WAY : int'(c);
    endfunction

    int rob_cap;
    int rs_cap;
    int lsq_cap;
    int mem_cnt;
    int mem_next;
    int cnt;
    logic ok;

    // Grow the prefix lane by lane until a lane is invalid or a resource runs out.
    always_comb begin
        rob_cap  = sat_way(rob_free);
        rs_cap   = sat_way(rs_free);
        lsq_cap  = sat_way(lsq_free);
        mem_cnt  = 0;
        mem_next = 0;
        cnt      = 0;
        ok       = 1'b1;
        fire     = '0;
        for (int k = 0; k < WAY; k++) begin
            if (ok && valid[k]) begin
                mem_next = mem_cnt + (mem_op[k] ? 1 : 0);
                if ((k + 1 <= rob_cap) && (k + 1 <= rs_cap) && (mem_next <= lsq_cap)) begin
                    fire[k] = 1'b1;
                    cnt     = k + 1;
                    mem_cnt = mem_next;
                end else begin
                    ok = 1'b0;
                end
            end else begin
                ok = 1'b0;
            end
        end
        n = NW'(cnt);
    end
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: holds one decoded group from id_stage and releases it to
// ROB/RS/LSQ in program order as free entries allow.
// Optional feature macro: DISPATCH_PERF_EN enables the stall-cycle counter;
// without it stall_cycles_o is tied to zero.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int WAY   = WAY_NUM,
    parameter int CNT_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    dispatch_ctrl_if.slave  bus,
    output logic [31:0]     stall_cycles_o,
    output DISP_STATE       dbg_state
);
    localparam int NW = $clog2(WAY+1);

    DISP_STATE                   state;
    ID_DISPATCH_PACKET [WAY-1:0] buf_pkt;
    ID_DISPATCH_PACKET [WAY-1:0] sh_pkt;
    logic [WAY-1:0]              buf_vld;
    logic [WAY-1:0]              sh_vld;
    logic [WAY-1:0]              mem_op;
    logic [WAY-1:0]              fire;
    logic [NW-1:0]               n;
    logic                        drain_all;
    logic                        ready;
    logic                        accept;

    // Per-lane LSQ demand of the buffered group.
    always_comb begin
        mem_op = '0;
        for (int k = 0; k < WAY; k++) begin
            mem_op[k] = is_lsq_op(buf_pkt[k]);
        end
    end

    disp_width_calc #(
        .WAY   (WAY),
        .CNT_W (CNT_W)
    ) u_width (
        .valid    (buf_vld),
        .mem_op   (mem_op),
        .rob_free (bus.rob_free_i),
        .rs_free  (bus.rs_free_i),
        .lsq_free (bus.lsq_free_i),
        .n        (n),
        .fire     (fire)
    );

    // fire is a prefix of buf_vld, so equality means every valid lane leaves.
    assign drain_all = (state == HOLD) && (fire == buf_vld);
    assign ready     = reset && !bus.flush_i && ((state == EMPTY) || drain_all);
    assign accept    = ready && (|bus.id_valid_i);

    assign bus.id_ready_o    = ready;
    assign bus.disp_packet_o = buf_pkt;
    assign bus.disp_valid_o  = (reset && !bus.flush_i && (state == HOLD)) ? fire : '0;
    assign dbg_state         = state;

    // Remaining lanes after dispatching n: lane k takes lane k+n.
    always_comb begin
        for (int k = 0; k < WAY; k++) begin
            sh_vld[k] = 1'b0;
            sh_pkt[k] = '0;
            for (int j = 0; j < WAY; j++) begin
                if (j == k + int'(n)) begin
                    sh_vld[k] = buf_vld[j];
                    sh_pkt[k] = buf_pkt[j];
                end
            end
        end
    end

    // Group buffer and EMPTY/HOLD/FLUSH sequencing; flush beats everything but reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= EMPTY;
            buf_vld <= '0;
            buf_pkt <= '0;
        end else if (bus.flush_i) begin
            state   <= FLUSH;
            buf_vld <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        buf_pkt <= bus.id_packet_i;
                        buf_vld <= bus.id_valid_i;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (drain_all) begin
                        if (accept) begin
                            buf_pkt <= bus.id_packet_i;
                            buf_vld <= bus.id_valid_i;
                            state   <= HOLD;
                        end else begin
                            buf_vld <= '0;
                            state   <= EMPTY;
                        end
                    end else begin
                        buf_pkt <= sh_pkt;
                        buf_vld <= sh_vld;
                    end
                end
                FLUSH: begin
                    state <= EMPTY;
                end
                default: begin
                    state   <= EMPTY;
                    buf_vld <= '0;
                end
            endcase
        end
    end

`ifdef DISPATCH_PERF_EN
    logic        stall;
    logic [31:0] stall_cnt;

    assign stall = (state == HOLD) && (fire != buf_vld);

    // Saturating count of cycles where some buffered lane had to wait.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (bus.flush_i) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl (WAY=2, CNT_W=4) with hand-computed
// expectations; the stall-counter expectation follows DISPATCH_PERF_EN.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

`ifdef DISPATCH_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] stall_cycles;
    DISP_STATE   st;

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_ctrl_if #(.WAY(2), .CNT_W(4)) bus ();

    dispatch_ctrl #(.WAY(2), .CNT_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .stall_cycles_o (stall_cycles),
        .dbg_state      (st)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [7:0] t0, input logic [7:0] t1,
                         input logic m0, input logic m1, input logic [1:0] v);
        ID_DISPATCH_PACKET p;
        p = '0; p.tag = t0; p.dest = 5'd1; p.rd_mem = m0;
        bus.id_packet_i[0] = p;
        p = '0; p.tag = t1; p.dest = 5'd2; p.rd_mem = m1;
        bus.id_packet_i[1] = p;
        bus.id_valid_i = v;
    endtask

    task automatic set_free(input logic [3:0] rob, input logic [3:0] rs, input logic [3:0] lsq);
        bus.rob_free_i = rob;
        bus.rs_free_i  = rs;
        bus.lsq_free_i = lsq;
    endtask

    initial begin
        reset = 1'b0;
        bus.flush_i = 1'b0;
        set_free(4'd4, 4'd4, 4'd4);
        offer(8'd0, 8'd0, 1'b0, 1'b0, 2'b11);
        step();
        step();
        settle();
        check("rst_ready",  32'(bus.id_ready_o), 32'd0);
        check("rst_disp",   32'(bus.disp_valid_o), 32'd0);
        check("rst_state",  32'(st), 32'(EMPTY));
        check("rst_stall",  stall_cycles, 32'd0);
        bus.id_valid_i = 2'b00;
        reset = 1'b1;
        step();

        // Two lanes, plenty of room: accept, dispatch both, back to EMPTY.
        offer(8'd1, 8'd2, 1'b0, 1'b0, 2'b11);
        settle();
        check("full_accept", 32'(bus.id_ready_o), 32'd1);
        step();
        bus.id_valid_i = 2'b00;
        settle();
        check("full_state_hold", 32'(st), 32'(HOLD));
        check("full_disp",  32'(bus.disp_valid_o), 32'd3);
        check("full_tag0",  32'(bus.disp_packet_o[0].tag), 32'd1);
        check("full_tag1",  32'(bus.disp_packet_o[1].tag), 32'd2);
        check("full_ready", 32'(bus.id_ready_o), 32'd1);
        step();
        check("full_empty", 32'(st), 32'(EMPTY));
        check("full_idle",  32'(bus.disp_valid_o), 32'd0);

        // ROB limited to one entry: partial dispatch, shift, then finish.
        offer(8'd3, 8'd4, 1'b0, 1'b0, 2'b11);
        step();
        bus.id_valid_i = 2'b00;
        set_free(4'd1, 4'd4, 4'd4);
        settle();
        check("rob1_disp",  32'(bus.disp_valid_o), 32'd1);
        check("rob1_ready", 32'(bus.id_ready_o), 32'd0);
        step();
        check("rob1_stall", stall_cycles, 32'(PERF * 1));
        check("rob1_shift", 32'(bus.disp_packet_o[0].tag), 32'd4);
        set_free(4'd2, 4'd4, 4'd4);
        settle();
        check("rob2_disp",  32'(bus.disp_valid_o), 32'd1);
        check("rob2_ready", 32'(bus.id_ready_o), 32'd1);
        step();
        check("rob2_empty", 32'(st), 32'(EMPTY));
        check("rob2_stall", stall_cycles, 32'(PERF * 1));

        // Two loads, one LSQ slot.
        set_free(4'd4, 4'd4, 4'd1);
        offer(8'd5, 8'd6, 1'b1, 1'b1, 2'b11);
        step();
        bus.id_valid_i = 2'b00;
        settle();
        check("lsq1_disp", 32'(bus.disp_valid_o), 32'd1);
        step();
        check("lsq1_stall", stall_cycles, 32'(PERF * 2));
        check("lsq1_tag",  32'(bus.disp_packet_o[0].tag), 32'd6);
        check("lsq1_disp2", 32'(bus.disp_valid_o), 32'd1);
        step();
        check("lsq1_empty", 32'(st), 32'(EMPTY));

        // Zero RS entries blocks everything; oversize counts saturate.
        set_free(4'd4, 4'd0, 4'd4);
        offer(8'd7, 8'd8, 1'b0, 1'b1, 2'b11);
        step();
        bus.id_valid_i = 2'b00;
        settle();
        check("rs0_disp",  32'(bus.disp_valid_o), 32'd0);
        check("rs0_ready", 32'(bus.id_ready_o), 32'd0);
        step();
        check("rs0_stall", stall_cycles, 32'(PERF * 3));
        set_free(4'd15, 4'd15, 4'd15);
        settle();
        check("sat_disp",  32'(bus.disp_valid_o), 32'd3);
        check("sat_ready", 32'(bus.id_ready_o), 32'd1);
        step();
        check("sat_empty", 32'(st), 32'(EMPTY));
        set_free(4'd4, 4'd4, 4'd4);

        // Flush while HOLD could fully drain and a new group is offered.
        offer(8'd9, 8'd10, 1'b0, 1'b0, 2'b11);
        step();
        offer(8'd11, 8'd12, 1'b0, 1'b0, 2'b11);
        bus.flush_i = 1'b1;
        settle();
        check("fl_disp",  32'(bus.disp_valid_o), 32'd0);
        check("fl_ready", 32'(bus.id_ready_o), 32'd0);
        step();
        check("fl_state", 32'(st), 32'(FLUSH));
        check("fl_stall", stall_cycles, 32'd0);
        step();
        check("fl_held", 32'(st), 32'(FLUSH));
        bus.flush_i = 1'b0;
        settle();
        check("fl_noacc", 32'(bus.id_ready_o), 32'd0);
        check("fl_nodisp", 32'(bus.disp_valid_o), 32'd0);
        step();
        bus.id_valid_i = 2'b00;
        settle();
        check("fl_empty", 32'(st), 32'(EMPTY));
        check("fl_ready_after", 32'(bus.id_ready_o), 32'd1);
        check("fl_dropped", 32'(bus.disp_valid_o), 32'd0);

        // Reset in the middle of a stalled HOLD.
        offer(8'd13, 8'd14, 1'b0, 1'b0, 2'b11);
        step();
        bus.id_valid_i = 2'b00;
        set_free(4'd1, 4'd4, 4'd4);
        step();
        check("mr_pre_stall", stall_cycles, 32'(PERF * 1));
        reset = 1'b0;
        step();
        check("mr_state", 32'(st), 32'(EMPTY));
        check("mr_disp",  32'(bus.disp_valid_o), 32'd0);
        check("mr_ready", 32'(bus.id_ready_o), 32'd0);
        check("mr_stall", stall_cycles, 32'd0);
        reset = 1'b1;
        set_free(4'd4, 4'd4, 4'd4);
        step();
        check("mr_post_disp",  32'(bus.disp_valid_o), 32'd0);
        check("mr_post_state", 32'(st), 32'(EMPTY));
        check("mr_post_stall", stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
